// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the MEM stage. It takes one read or write request
// at a time, serves it from an internal word array after LATENCY wait states,
// holds the pipeline with stall until the access finishes, and returns read
// data for the MEM/WB register.
//
// Handshake: a request is present when exactly one of memR/memWR is high. The
// pipeline must hold memR/memWR/addr/dataWR stable while stall is high. The
// access is complete in the single cycle where ready is high; the pipeline
// advances on that cycle's edge. Inputs are only sampled in IDLE, so a request
// still showing during DONE is ignored and only re-accepted in the next IDLE.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   memR       read request
//   memWR      write request
//   addr       word address
//   dataWR     write data
//   dataR      registered read data (holds last read result)
//   ready      one-cycle completion pulse (decode of DONE)
//   stall      combinational pipeline freeze
//   err        combinational illegal-request flag (memR and memWR both high)
//   state_dbg  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memR,
    input  logic              memWR,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataWR,
    output logic [DATA_W-1:0] dataR,
    output logic              ready,
    output logic              stall,
    output logic              err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] data_r_q, data_r_d;

    logic              req_valid;
    logic              commit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_wr;

    // With LATENCY==0 the array is accessed on the same edge that accepts the
    // request, before the latch holds it, so the access uses the live inputs
    // while in IDLE and the latched copy otherwise.
    always_comb begin
        acc_addr  = (state_q == S_IDLE) ? addr   : addr_q;
        acc_wdata = (state_q == S_IDLE) ? dataWR : wdata_q;
        acc_wr    = (state_q == S_IDLE) ? memWR  : is_wr_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        commit    = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        req_valid = memR ^ memWR;

        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                err   = memR & memWR;
                if (req_valid) begin
                    addr_d  = addr;
                    wdata_d = dataWR;
                    is_wr_d = memWR;
                    if (LATENCY == 0) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT4;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_r_d = (commit && !acc_wr) ? mem[acc_addr] : data_r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            data_r_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            data_r_q <= data_r_d;
        end
    end

    // The array is never reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc_wr) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign dataR     = data_r_q;
    assign ready     = (state_q == S_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;

    // Index 0: LATENCY=0 instance, index 1: LATENCY=2 instance.
    logic              clk;
    logic              rst;
    logic              mem_r   [2];
    logic              mem_wr  [2];
    logic [ADDR_W-1:0] addr    [2];
    logic [DATA_W-1:0] data_wr [2];
    logic [DATA_W-1:0] data_r  [2];
    logic              ready   [2];
    logic              stall   [2];
    logic              err     [2];
    logic [1:0]        st      [2];

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .memR(mem_r[0]), .memWR(mem_wr[0]), .addr(addr[0]),
        .dataWR(data_wr[0]), .dataR(data_r[0]), .ready(ready[0]), .stall(stall[0]),
        .err(err[0]), .state_dbg(st[0])
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .memR(mem_r[1]), .memWR(mem_wr[1]), .addr(addr[1]),
        .dataWR(data_wr[1]), .dataR(data_r[1]), .ready(ready[1]), .stall(stall[1]),
        .err(err[1]), .state_dbg(st[1])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks are entered right after a falling edge and return on one.
    task automatic drive_req(input int d, input bit rd, input bit wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        mem_r[d]   = rd;
        mem_wr[d]  = wr;
        addr[d]    = a;
        data_wr[d] = wd;
    endtask

    task automatic drop_req(input int d);
        mem_r[d]  = 1'b0;
        mem_wr[d] = 1'b0;
    endtask

    // Walk the stall window (1+lat cycles) and check the DONE cycle.
    task automatic wait_done(input int d, input int lat, input logic [DATA_W-1:0] exp_dr,
                             input string tag);
        for (int i = 0; i <= lat; i++) begin
            check({tag, "_stall"}, 32'(stall[d]), 32'd1);
            check({tag, "_ready_lo"}, 32'(ready[d]), 32'd0);
            check({tag, "_err_lo"}, 32'(err[d]), 32'd0);
            @(negedge clk);
        end
        check({tag, "_ready_hi"}, 32'(ready[d]), 32'd1);
        check({tag, "_stall_done"}, 32'(stall[d]), 32'd0);
        check({tag, "_dataR"}, 32'(data_r[d]), 32'(exp_dr));
    endtask

    task automatic access(input int d, input int lat, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input logic [DATA_W-1:0] exp_dr, input string tag);
        drive_req(d, !wr, wr, a, wd);
        #1;
        wait_done(d, lat, exp_dr, tag);
        drop_req(d);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(ready[d]), 32'd0);
        check({tag, "_state_idle"}, 32'(st[d]), 32'(ST_IDLE));
        check({tag, "_dataR_hold"}, 32'(data_r[d]), 32'(exp_dr));
    endtask

    // ---------------- scoreboard-driven sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            drop_req(d);
            addr[d]    = '0;
            data_wr[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_state", 32'(st[d]), 32'(ST_IDLE));
            check("rst_ready", 32'(ready[d]), 32'd0);
            check("rst_dataR", 32'(data_r[d]), 32'd0);
            check("rst_stall", 32'(stall[d]), 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
        end

        // 1: write 0x1234 to 0x005, LATENCY=2, dataR untouched
        access(1, 2, 1'b1, 12'h005, 16'h1234, 16'h0000, "t1_wr");

        // 2: read 0x005 back, then dataR holds for four idle cycles
        access(1, 2, 1'b0, 12'h005, 16'h0000, 16'h1234, "t2_rd");
        repeat (4) @(negedge clk);
        check("t2_dataR_4cyc", 32'(data_r[1]), 32'h1234);

        // 3: LATENCY=0 write/read at the top address
        access(0, 0, 1'b1, 12'hFFF, 16'hBEEF, 16'h0000, "t3_wr");
        access(0, 0, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF, "t3_rd");

        // 4: illegal request held for three cycles
        drive_req(1, 1'b1, 1'b1, 12'h005, 16'h5555);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t4_err", 32'(err[1]), 32'd1);
            check("t4_stall", 32'(stall[1]), 32'd0);
            check("t4_ready", 32'(ready[1]), 32'd0);
            check("t4_state", 32'(st[1]), 32'(ST_IDLE));
            @(negedge clk);
        end
        drop_req(1);
        @(negedge clk);
        check("t4_err_clear", 32'(err[1]), 32'd0);
        access(1, 2, 1'b0, 12'h005, 16'h0000, 16'h1234, "t4_rd");

        // 5: reset during the first WAIT cycle drops the write
        drive_req(1, 1'b0, 1'b1, 12'h005, 16'hAAAA);
        #1;
        check("t5_stall_c", 32'(stall[1]), 32'd1);
        @(negedge clk);
        check("t5_in_wait", 32'(st[1]), 32'd1);
        rst = 1'b1;
        drop_req(1);
        @(negedge clk);
        rst = 1'b0;
        check("t5_state", 32'(st[1]), 32'(ST_IDLE));
        check("t5_dataR", 32'(data_r[1]), 32'd0);
        check("t5_ready", 32'(ready[1]), 32'd0);
        @(negedge clk);
        check("t5_no_ready", 32'(ready[1]), 32'd0);
        access(1, 2, 1'b0, 12'h005, 16'h0000, 16'h1234, "t5_rd");

        // 6: read held through DONE is re-accepted as a fresh access
        drive_req(1, 1'b1, 1'b0, 12'h005, 16'h0000);
        #1;
        wait_done(1, 2, 16'h1234, "t6_a");
        @(negedge clk);
        check("t6_idle_after_done", 32'(st[1]), 32'(ST_IDLE));
        check("t6_single_pulse", 32'(ready[1]), 32'd0);
        wait_done(1, 2, 16'h1234, "t6_b");
        drop_req(1);
        @(negedge clk);
        check("t6_end_ready", 32'(ready[1]), 32'd0);
        check("t6_end_stall", 32'(stall[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
